// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: assembles a little-endian byte stream into 32-bit words and
// writes them into the IF-stage instruction memory. A load ends on the HALT word,
// when the memory depth is reached, or on overflow (memory reports full).
// Optional macro LOADER_TIMEOUT_EN adds an inter-byte idle timeout in RECV.
module imem_loader_ctrl #(
  parameter int unsigned                WORD_WIDTH_BITS = 32,
  parameter int unsigned                MEM_SIZE_WORDS  = 10,
  parameter logic [WORD_WIDTH_BITS-1:0] HALT_INSTR      = 32'hFFFF_FFFF,
  parameter int unsigned                TIMEOUT_CYCLES  = 1000000,
  parameter int unsigned                COUNT_WIDTH     = $clog2(MEM_SIZE_WORDS + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_load_start,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  input  logic                       i_mem_full,
  output logic                       o_clear,
  output logic                       o_inst_write,
  output logic [WORD_WIDTH_BITS-1:0] o_instruction,
  output logic                       o_busy,
  output logic                       o_load_done,
  output logic                       o_error,
  output logic [COUNT_WIDTH-1:0]     o_word_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [1:0]                 idx_q, idx_d;
  logic [WORD_WIDTH_BITS-1:0] instr_q, instr_d;
  logic [COUNT_WIDTH-1:0]     count_q, count_d;
  logic                       error_q, error_d;
  logic                       clear_q, clear_d;
  logic                       write_q, write_d;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  // Next-state and datapath decode. The write strobe and count are decided on the
  // edge that captures the 4th byte, so they are visible for the WRITE cycle itself.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    count_d = count_q;
    error_d = error_q;
    clear_d = 1'b0;
    write_d = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    idle_d  = idle_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_load_start) begin
          state_d = S_CLEAR;
          clear_d = 1'b1;
        end
      end
      S_CLEAR: begin
        count_d = '0;
        idx_d   = '0;
        instr_d = '0;
        error_d = 1'b0;
        state_d = S_RECV;
`ifdef LOADER_TIMEOUT_EN
        idle_d  = '0;
`endif
      end
      S_RECV: begin
        if (i_rx_valid) begin
          instr_d[{idx_q, 3'b000} +: 8] = i_rx_data;
          idx_d = idx_q + 2'd1;
`ifdef LOADER_TIMEOUT_EN
          idle_d = '0;
`endif
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            if (i_mem_full) begin
              error_d = 1'b1;
            end else begin
              write_d = 1'b1;
              count_d = count_q + COUNT_WIDTH'(1);
            end
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
`endif
      end
      S_WRITE: begin
`ifdef LOADER_TIMEOUT_EN
        idle_d = '0;
`endif
        if (!write_q || (instr_q == HALT_INSTR) || (count_q == COUNT_WIDTH'(MEM_SIZE_WORDS))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RECV;
        end
      end
      S_DONE: begin
        if (i_load_start) begin
          state_d = S_CLEAR;
          clear_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      instr_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
      clear_q <= 1'b0;
      write_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      count_q <= count_d;
      error_q <= error_d;
      clear_q <= clear_d;
      write_q <= write_d;
`ifdef LOADER_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign o_clear       = clear_q;
  assign o_inst_write  = write_q;
  assign o_instruction = instr_q;
  assign o_error       = error_q;
  assign o_word_count  = count_q;
  assign o_busy        = (state_q == S_CLEAR) || (state_q == S_RECV) || (state_q == S_WRITE);
  assign o_load_done   = (state_q == S_DONE);

endmodule
